// File: rtl/jump_ctrl_if.sv
// Signal bundle between the jump controller and the rest of the jump-game
// datapath: button, landing-checker verdict, stage-manager scroll and the
// controller's position/state outputs.
interface jump_ctrl_if;
   logic       press;
   logic       game_over;
   logic       on_second;
   logic       scroll_done;
   logic [9:0] scroll_shift;
   logic       restart;
   logic [9:0] man_x;
   logic [9:0] charge;
   logic       jumping;
   logic       land;
   logic       dead;

   // Environment side: drives the button, checker and scroll inputs.
   modport master (
      output press, game_over, on_second, scroll_done, scroll_shift, restart,
      input  man_x, charge, jumping, land, dead
   );

   // Controller side.
   modport slave (
      input  press, game_over, on_second, scroll_done, scroll_shift, restart,
      output man_x, charge, jumping, land, dead
   );
endinterface

// File: rtl/jump_ctrl.sv
// Player jump controller: converts button hold time into a jump distance,
// walks man_x one pixel at a time, then acts on the landing checker's verdict
// (back to idle, wait for the scene scroll, or freeze dead until restart).
module jump_ctrl #(
   parameter int CHARGE_DIV = 4,
   parameter int STEP_DIV   = 2,
   parameter int MAX_CHARGE = 300,
   parameter int X_INIT     = 100,
   parameter int X_MAX      = 639
) (
   input logic        clk,
   input logic        rst_n,
   jump_ctrl_if.slave bus
);

   localparam int PW = (CHARGE_DIV > 1) ? $clog2(CHARGE_DIV) : 1;
   localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

   localparam logic [PW-1:0] PRE_WRAP  = PW'(CHARGE_DIV - 1);
   localparam logic [SW-1:0] STEP_WRAP = SW'(STEP_DIV - 1);
   localparam logic [9:0]    CHG_SAT   = 10'(MAX_CHARGE);
   localparam logic [9:0]    X_START   = 10'(X_INIT);
   localparam logic [9:0]    X_LIMIT   = 10'(X_MAX);

   typedef enum logic [2:0] {
      IDLE,
      CHARGE,
      JUMP,
      LAND,
      WAIT_SCROLL,
      DEAD
   } state_t;

   state_t        state_q, state_d;
   logic          press_prev_q;
   logic [9:0]    man_x_q, man_x_d;
   logic [9:0]    charge_q, charge_d;
   logic [9:0]    remaining_q, remaining_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [SW-1:0] step_q, step_d;

   // State and datapath registers; press_prev resets high so a button held
   // through reset is not seen as a fresh press.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         press_prev_q <= 1'b1;
         man_x_q      <= X_START;
         charge_q     <= '0;
         remaining_q  <= '0;
         pre_q        <= '0;
         step_q       <= '0;
      end else begin
         state_q      <= state_d;
         press_prev_q <= bus.press;
         man_x_q      <= man_x_d;
         charge_q     <= charge_d;
         remaining_q  <= remaining_d;
         pre_q        <= pre_d;
         step_q       <= step_d;
      end
   end

   // Next-state and datapath update for each phase of a jump.
   // NOTE: every signal gets a hold default first, so no path through the
   // case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      man_x_d     = man_x_q;
      charge_d    = charge_q;
      remaining_d = remaining_q;
      pre_d       = pre_q;
      step_d      = step_q;

      case (state_q)
         IDLE: begin
            if (bus.press && !press_prev_q) begin
               state_d  = CHARGE;
               charge_d = '0;
               pre_d    = '0;
            end
         end

         CHARGE: begin
            if (bus.press) begin
               if (pre_q == PRE_WRAP) begin
                  pre_d = '0;
                  if (charge_q != CHG_SAT) charge_d = charge_q + 10'd1;
               end else begin
                  pre_d = pre_q + 1'b1;
               end
            end else if (charge_q == '0) begin
               // Tap too short to earn any distance: no jump, no landing.
               state_d = IDLE;
            end else begin
               state_d     = JUMP;
               remaining_d = charge_q;
               step_d      = '0;
            end
         end

         JUMP: begin
            if (man_x_q >= X_LIMIT) begin
               // Already at the right edge: land without moving.
               state_d = LAND;
            end else if (step_q == STEP_WRAP) begin
               step_d      = '0;
               man_x_d     = man_x_q + 10'd1;
               remaining_d = remaining_q - 10'd1;
               if (remaining_q == 10'd1 || man_x_q + 10'd1 == X_LIMIT)
                  state_d = LAND;
            end else begin
               step_d = step_q + 1'b1;
            end
         end

         LAND: begin
            if (bus.game_over)      state_d = DEAD;
            else if (bus.on_second) state_d = WAIT_SCROLL;
            else                    state_d = IDLE;
         end

         WAIT_SCROLL: begin
            if (bus.scroll_done) begin
               man_x_d = (man_x_q > bus.scroll_shift) ? man_x_q - bus.scroll_shift : '0;
               state_d = IDLE;
            end
         end

         DEAD: begin
            if (bus.restart) begin
               state_d = IDLE;
               man_x_d = X_START;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign bus.man_x   = man_x_q;
   assign bus.charge  = charge_q;
   assign bus.jumping = (state_q == CHARGE) || (state_q == JUMP);
   assign bus.land    = (state_q == LAND);
   assign bus.dead    = (state_q == DEAD);

endmodule

// File: tb/tb_jump_ctrl.sv
// Bench for jump_ctrl: directed button/checker/scroll sequences. Each jump
// pushes its expected landing position and charge into a queue; a monitor
// pops and compares on every land pulse.
module tb_jump_ctrl;

   typedef struct {
      logic [9:0] x;
      logic [9:0] c;
   } land_exp_t;

   logic clk = 1'b0;
   logic rst_n;

   jump_ctrl_if bus ();

   jump_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   land_exp_t exp_q[$];
   int n_checks  = 0;
   int n_fail    = 0;
   int n_lands   = 0;
   int exp_lands = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Landing monitor: every land pulse must match the oldest expected landing.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.land === 1'b1) begin
         n_lands++;
         if (exp_q.size() == 0) begin
            check("unexpected_land", 1, 0);
         end else begin
            land_exp_t e;
            e = exp_q.pop_front();
            check("land_man_x", bus.man_x, e.x);
            check("land_charge", bus.charge, e.c);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Rising edge, then 'hold' further high cycles in CHARGE, then release.
   task automatic press_hold(input int hold);
      bus.press = 1'b1;
      tick(1);
      tick(hold);
      bus.press = 1'b0;
   endtask

   task automatic wait_land(input int budget);
      int i;
      for (i = 0; i < budget; i++) begin
         @(negedge clk);
         #1;
         if (n_lands >= exp_lands) break;
      end
      if (i == budget) check("land_timeout", 0, 1);
   endtask

   task automatic do_jump(input int hold, input int exp_c, input int exp_x);
      land_exp_t e;
      e.x = 10'(exp_x);
      e.c = 10'(exp_c);
      exp_q.push_back(e);
      exp_lands++;
      press_hold(hold);
      wait_land(1000);
      tick(1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected it to");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.press        = 1'b1;
      bus.game_over    = 1'b0;
      bus.on_second    = 1'b0;
      bus.scroll_done  = 1'b0;
      bus.scroll_shift = '0;
      bus.restart      = 1'b0;
      rst_n            = 1'b0;

      // Reset values, with the button already held.
      #12;
      check("rst_man_x", bus.man_x, 100);
      check("rst_charge", bus.charge, 0);
      check("rst_jumping", bus.jumping, 0);
      check("rst_land", bus.land, 0);
      check("rst_dead", bus.dead, 0);
      tick(1);
      rst_n = 1'b1;
      tick(10);
      check("held_through_reset_jumping", bus.jumping, 0);
      bus.press = 1'b0;
      tick(2);

      // Basic jump: 40 counted cycles -> charge 10 -> 100 + 10.
      do_jump(40, 10, 110);
      check("after_land_jumping", bus.jumping, 0);
      check("after_land_dead", bus.dead, 0);

      // Tap shorter than one charge unit: no jump, charge cleared.
      press_hold(2);
      tick(6);
      check("tap_man_x", bus.man_x, 110);
      check("tap_charge", bus.charge, 0);
      check("tap_jumping", bus.jumping, 0);

      // Land on the second stage, scroll by 85 with a coincident press edge.
      bus.on_second = 1'b1;
      do_jump(20, 5, 115);
      check("wait_scroll_jumping", bus.jumping, 0);
      check("wait_scroll_man_x", bus.man_x, 115);
      bus.press        = 1'b1;
      bus.scroll_done  = 1'b1;
      bus.scroll_shift = 10'd85;
      tick(1);
      bus.scroll_done  = 1'b0;
      check("scroll_man_x", bus.man_x, 30);
      tick(3);
      check("scroll_press_lost", bus.jumping, 0);
      bus.press = 1'b0;
      tick(1);

      // Second-stage landing again, scroll larger than position -> 0.
      do_jump(20, 5, 35);
      bus.scroll_done  = 1'b1;
      bus.scroll_shift = 10'd200;
      tick(1);
      bus.scroll_done  = 1'b0;
      bus.on_second    = 1'b0;
      check("scroll_sat_man_x", bus.man_x, 0);

      // Charge saturation at 300, then stop at the right edge.
      do_jump(2000, 300, 300);
      do_jump(1250, 300, 600);
      bus.game_over = 1'b1;
      do_jump(1250, 300, 639);
      bus.game_over = 1'b0;

      // Dead: frozen under button activity.
      check("dead_flag", bus.dead, 1);
      bus.press = 1'b1; tick(2);
      bus.press = 1'b0; tick(2);
      bus.press = 1'b1; tick(1);
      check("dead_man_x", bus.man_x, 639);
      check("dead_charge", bus.charge, 300);
      check("dead_jumping", bus.jumping, 0);
      bus.restart = 1'b1;
      tick(1);
      bus.restart = 1'b0;
      check("restart_man_x", bus.man_x, 100);
      check("restart_dead", bus.dead, 0);
      tick(3);
      check("restart_press_ignored", bus.jumping, 0);
      bus.press = 1'b0;
      tick(1);

      // Asynchronous reset in the middle of a jump at man_x = 105.
      press_hold(40);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.man_x == 10'd105) break;
      end
      check("mid_jump_reached_105", bus.man_x, 105);
      check("mid_jump_jumping", bus.jumping, 1);
      #1;
      rst_n = 1'b0;
      #1;
      check("async_rst_man_x", bus.man_x, 100);
      check("async_rst_jumping", bus.jumping, 0);
      check("async_rst_charge", bus.charge, 0);
      tick(2);
      rst_n = 1'b1;
      tick(5);

      check("pending_landings", exp_q.size(), 0);
      check("land_count", n_lands, exp_lands);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/jump_ctrl.md
# jump_ctrl

Player jump controller for the jump-game datapath. It measures how long the player holds the jump button and converts that into a horizontal jump distance. It then animates the character's x position pixel by pixel and produces `man_x` for the combinational landing checker. On landing it samples the checker's verdict (`game_over`, `on_second`) and either returns to idle, waits for the stage manager to scroll the scene, or freezes in a dead state.

## Interface
- `CHARGE_DIV`, default 4: cycles of held button per unit of charge (≥1).
- `STEP_DIV`, default 2: cycles per 1-pixel move during a jump (≥1).
- `MAX_CHARGE`, default 300: charge saturation value, in pixels.
- `X_INIT`, default 100: `man_x` after reset and after restart.
- `X_MAX`, default 639: rightmost legal `man_x`.

Ports:
- `clk` input 1: system clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `press` input 1: debounced jump button level, synchronous to `clk`.
- `game_over` input 1: from landing checker, combinational on `man_x`.
- `on_second` input 1: from landing checker, combinational on `man_x`.
- `scroll_done` input 1: one-cycle pulse from the stage manager when the scroll is complete.
- `scroll_shift` input 10: pixels the scene moved, valid with `scroll_done`.
- `restart` input 1: one-cycle pulse that leaves DEAD.
- `man_x` output 10: character x position, registered.
- `charge` output 10: current or last charge in pixels, registered.
- `jumping` output 1: high in CHARGE and JUMP.
- `land` output 1: one-cycle pulse in LAND; checker outputs are valid in this cycle.
- `dead` output 1: high in DEAD.

## Operation
- States: IDLE, CHARGE, JUMP, LAND, WAIT_SCROLL, DEAD.
- Rising-edge detection uses registered `press_d`. `press_d` resets to 1, so a button held through reset does not trigger a jump.
- **IDLE**
  - `press & ~press_d` → CHARGE.
  - Clear `charge` and the prescaler. The detecting cycle does not count toward charge.
- **CHARGE**
  - Each cycle with `press`=1, the prescaler increments.
  - When the prescaler reaches `CHARGE_DIV-1` it wraps to 0 and `charge` increments, saturating at `MAX_CHARGE`.
  - `press`=0 → JUMP with `remaining`=`charge`. If `charge`=0 → IDLE instead, with no `land`.
- **JUMP**
  - Every `STEP_DIV` cycles: `man_x`+=1 and `remaining`-=1.
  - `remaining`=0 → LAND.
  - If `man_x`=`X_MAX` with `remaining`>0, stop moving and go to LAND.
- **LAND** (exactly one cycle, `land`=1). Transition is decided on that cycle's inputs:
  - `game_over` → DEAD.
  - else `on_second` → WAIT_SCROLL.
  - else → IDLE (landed back on the first stage).
- **WAIT_SCROLL**
  - On `scroll_done`: `man_x` ← `man_x` − `scroll_shift`, saturating at 0. Then → IDLE.
  - `press` is ignored.
- **DEAD**
  - `man_x` and `charge` hold.
  - `restart` → IDLE with `man_x`=`X_INIT`.
  - `press` is ignored.
- `press` edges outside IDLE are ignored. The player must release and press again once in IDLE.
- `charge` holds its value after the jump until the next CHARGE entry, for display.

## Timing
- Reset values: state IDLE, `man_x`=`X_INIT`, `charge`=0, `jumping`=0, `land`=0, `dead`=0, `press_d`=1, prescaler and step counter 0.
- All outputs are registered. State outputs (`jumping`, `dead`, `land`) are decoded from the state register and are valid in the state's own cycles.
- Charge length: N cycles in CHARGE with `press`=1 gives `charge` = min(floor(N/`CHARGE_DIV`), `MAX_CHARGE`).
- Jump length: D pixels takes D·`STEP_DIV` cycles in JUMP. LAND follows on the next cycle.
- `land` asserts one cycle after the final `man_x` update, so `man_x` is stable while the checker evaluates.
- Simultaneous `scroll_done` and `press` edge in WAIT_SCROLL: the scroll is applied and the edge is lost.
- Simultaneous `restart` and `press` in DEAD: restart only.
- `rst_n` low mid-jump restores the reset values immediately, asynchronously.

## Test plan
- Defaults. Press rising edge, then 40 more high cycles, then release → `charge`=10, 20 cycles of JUMP, `man_x`=110, `land` pulses once.
- Hold `press` for 2000 cycles → `charge` saturates at 300. The jump stops at `man_x`=`X_MAX` (639) with `land`=1 on the next cycle.
- LAND with `on_second`=1, `game_over`=0, then `scroll_done` with `scroll_shift`=80 at `man_x`=110 → `man_x`=30, state IDLE. Also `scroll_shift`=200 → `man_x`=0.
- LAND with `game_over`=1 → `dead`=1, `man_x` frozen under `press` toggling. `restart` → `man_x`=100, `dead`=0.
- Press and release within 3 cycles (`charge`=0) → returns to IDLE, no `land`, `man_x` unchanged. `press` held across reset deassertion → no CHARGE entry.
- Assert `rst_n`=0 mid-JUMP at `man_x`=105 → `man_x`=100, `jumping`=0 without waiting for a clock edge.
